// File: rtl/count_seq_ctrl.sv
// Launchable 4-bit up-counter with one-shot/periodic modes, pause/resume and abort.
// Terminal count, mode and wrap statistics are all held in registers; only busy is decoded.
module count_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic [1:0]   state,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] wraps
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [W-1:0] WRAP_MAX = '1;

    state_t       st;
    logic [W-1:0] lim_r;
    logic         mode_r;
    logic         launch;
    logic         at_term;

    assign launch  = start && !stop;
    assign at_term = (q == lim_r);
    assign state   = st;
    assign busy    = (st == RUN) || (st == HALT);

    // done defaults low every edge; only the terminal-count branches raise it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= IDLE;
            q      <= '0;
            done   <= 1'b0;
            wraps  <= '0;
            lim_r  <= '0;
            mode_r <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (launch) begin
                        q      <= '0;
                        wraps  <= '0;
                        lim_r  <= limit;
                        mode_r <= mode;
                        st     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        st <= HALT;
                    end else if (!at_term) begin
                        q <= q + 1'b1;
                    end else if (!mode_r) begin
                        done <= 1'b1;
                        st   <= DONE;
                    end else begin
                        q    <= '0;
                        done <= 1'b1;
                        if (wraps != WRAP_MAX)
                            wraps <= wraps + 1'b1;
                    end
                end
                HALT: begin
                    // stop while paused is an abort; the wrap tally survives it
                    if (stop) begin
                        q  <= '0;
                        st <= IDLE;
                    end else if (start) begin
                        st <= RUN;
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: expected values are hand-derived per step.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, mode;
    logic [3:0] limit;
    logic [3:0] q, wraps;
    logic [1:0] state;
    logic       busy, done;

    int ncmp = 0;
    int nfail = 0;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10, S_DONE = 2'b11;

    count_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .limit(limit), .q(q), .state(state), .busy(busy), .done(done), .wraps(wraps)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] eq, input logic [1:0] est,
                             input logic edone);
        chk({tag, ".q"}, {4'h0, q}, {4'h0, eq});
        chk({tag, ".state"}, {6'h0, state}, {6'h0, est});
        chk({tag, ".done"}, {7'h0, done}, {7'h0, edone});
        chk({tag, ".busy"}, {7'h0, busy}, {7'h0, (est == S_RUN || est == S_HALT)});
    endtask

    task automatic launch(input logic [3:0] lim, input logic md);
        limit = lim; mode = md; start = 1'b1; stop = 1'b0;
        step();
        start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = 4'h0;
        #3;
        expect_st("reset", 4'h0, S_IDLE, 1'b0);
        chk("reset.wraps", {4'h0, wraps}, 8'h0);
        #4 rst = 1'b1;
        step();
        expect_st("idle_after_reset", 4'h0, S_IDLE, 1'b0);

        // one-shot to 5; limit changes mid-run must not matter
        launch(4'd5, 1'b0);
        expect_st("os.launch", 4'h0, S_RUN, 1'b0);
        limit = 4'd2; mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_st("os.count", i[3:0], S_RUN, 1'b0);
        end
        step();
        expect_st("os.term", 4'd5, S_DONE, 1'b1);
        step();
        expect_st("os.idle", 4'd5, S_IDLE, 1'b0);

        // periodic, limit 3, start held: 20 wraps saturate at 15
        limit = 4'd3; mode = 1'b1; start = 1'b1; stop = 1'b0;
        step();
        expect_st("per.launch", 4'h0, S_RUN, 1'b0);
        for (int k = 1; k <= 80; k++) begin
            step();
            expect_st("per.cycle", 4'(k % 4), S_RUN, (k % 4) == 0);
            chk("per.wraps", {4'h0, wraps}, 8'((k / 4) > 15 ? 15 : (k / 4)));
        end
        start = 1'b0; stop = 1'b1;
        step();
        expect_st("per.halt", 4'h0, S_HALT, 1'b0);
        step();
        expect_st("per.abort", 4'h0, S_IDLE, 1'b0);
        chk("per.wraps_held", {4'h0, wraps}, 8'd15);

        // start and stop together in IDLE: no launch
        start = 1'b1; stop = 1'b1; limit = 4'd7; mode = 1'b0;
        step();
        expect_st("both_idle", 4'h0, S_IDLE, 1'b0);
        chk("both_idle.wraps", {4'h0, wraps}, 8'd15);
        start = 1'b0; stop = 1'b0;

        // pause at 4, hold, resume to 9
        launch(4'd9, 1'b0);
        for (int i = 1; i <= 4; i++) step();
        expect_st("pr.at4", 4'd4, S_RUN, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        expect_st("pr.halt0", 4'd4, S_HALT, 1'b0);
        step();
        expect_st("pr.halt1", 4'd4, S_HALT, 1'b0);
        step();
        expect_st("pr.halt2", 4'd4, S_HALT, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        expect_st("pr.resume", 4'd4, S_RUN, 1'b0);
        done_cnt = 0;
        for (int i = 5; i <= 9; i++) begin
            step();
            if (done) done_cnt++;
            expect_st("pr.count", i[3:0], S_RUN, 1'b0);
        end
        step();
        if (done) done_cnt++;
        expect_st("pr.term", 4'd9, S_DONE, 1'b1);
        step();
        if (done) done_cnt++;
        expect_st("pr.idle", 4'd9, S_IDLE, 1'b0);
        chk("pr.done_count", 8'(done_cnt), 8'd1);

        // stop beats terminal compare, then stop in HALT aborts
        launch(4'd2, 1'b0);
        step();
        step();
        expect_st("pri.at_lim", 4'd2, S_RUN, 1'b0);
        stop = 1'b1;
        step();
        expect_st("pri.halt", 4'd2, S_HALT, 1'b0);
        step();
        stop = 1'b0;
        expect_st("pri.abort", 4'h0, S_IDLE, 1'b0);

        // limit 0 periodic: done every RUN cycle, q pinned at 0
        launch(4'd0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            expect_st("lim0p", 4'h0, S_RUN, 1'b1);
            chk("lim0p.wraps", {4'h0, wraps}, 8'(i));
        end
        stop = 1'b1;
        step();
        expect_st("lim0p.halt", 4'h0, S_HALT, 1'b0);
        step();
        stop = 1'b0;

        // limit 0 one-shot: DONE after first RUN cycle
        launch(4'd0, 1'b0);
        step();
        expect_st("lim0o.term", 4'h0, S_DONE, 1'b1);
        step();
        expect_st("lim0o.idle", 4'h0, S_IDLE, 1'b0);

        // limit 15 one-shot: terminal at 15 without wrapping
        launch(4'd15, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step();
            expect_st("lim15", i[3:0], S_RUN, 1'b0);
        end
        step();
        expect_st("lim15.term", 4'd15, S_DONE, 1'b1);
        step();
        expect_st("lim15.idle", 4'd15, S_IDLE, 1'b0);

        // async reset mid-count at q=7 with one wrap recorded
        launch(4'd8, 1'b1);
        for (int i = 1; i <= 16; i++) step();
        expect_st("rst.pre", 4'd7, S_RUN, 1'b0);
        chk("rst.pre_wraps", {4'h0, wraps}, 8'd1);
        rst = 1'b0;
        #2;
        expect_st("rst.async", 4'h0, S_IDLE, 1'b0);
        chk("rst.async_wraps", {4'h0, wraps}, 8'd0);
        #1 rst = 1'b1;
        step();
        expect_st("rst.after", 4'h0, S_IDLE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
